// File: rtl/fsmc_interface.sv
`default_nettype none
// ============================================================================
// Module   : fsmc_interface
// Brief    : Slave bridge from a multiplexed-A/D MCU FSMC/FMC bus to fabric.
//            Latches the address region, decodes a one-hot chip select,
//            captures write data and serves read data back onto AD.
// Revision : 1.0 - initial release
// ============================================================================
module fsmc_interface #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              NADV,
  input  logic              NWE,
  input  logic              NOE,
  inout  wire  [ADDR_W-1:0] AD,
  output logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] wr_data,
  output logic [3:0]        cs,
  output logic              state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_LATCHED = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;

  logic [SYNC_STAGES-1:0] nadv_sync_q;
  logic [SYNC_STAGES-1:0] nwe_sync_q;
  logic [SYNC_STAGES-1:0] noe_sync_q;
  // The address region bits are delayed by the same number of stages as
  // NADV so the value latched lines up with the synchronised strobe; the
  // MCU may already have switched AD to data by the time NADV_s rises.
  logic [1:0]             ad_hi_pipe_q [SYNC_STAGES];

  logic                   nadv_s;
  logic                   nwe_s;
  logic                   noe_s;
  logic [1:0]             ad_hi_dly;

  logic [2:0]             fsm_q;
  logic [2:0]             fsm_d;
  // Only the region bits feed the chip-select decode, so only they are kept.
  logic [1:0]             addr_hi_q;
  logic [3:0]             cs_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rd_data_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   drive_q;

  assign nadv_s    = nadv_sync_q[SYNC_STAGES-1];
  assign nwe_s     = nwe_sync_q[SYNC_STAGES-1];
  assign noe_s     = noe_sync_q[SYNC_STAGES-1];
  assign ad_hi_dly = ad_hi_pipe_q[SYNC_STAGES-1];

  // Synchronise the asynchronous strobes and the delayed address region bits
  always_ff @(posedge clk) begin
    if (reset_n) begin
      nadv_sync_q <= '1;
      nwe_sync_q  <= '1;
      noe_sync_q  <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        ad_hi_pipe_q[i] <= '0;
      end
    end else begin
      nadv_sync_q[0]  <= NADV;
      nwe_sync_q[0]   <= NWE;
      noe_sync_q[0]   <= NOE;
      ad_hi_pipe_q[0] <= AD[ADDR_W-1 -: 2];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        nadv_sync_q[i]  <= nadv_sync_q[i-1];
        nwe_sync_q[i]   <= nwe_sync_q[i-1];
        noe_sync_q[i]   <= noe_sync_q[i-1];
        ad_hi_pipe_q[i] <= ad_hi_pipe_q[i-1];
      end
    end
  end

  // Next-state decode; a new address phase always pre-empts a data phase
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE: begin
        if (!nadv_s) fsm_d = S_ADDR;
      end
      S_ADDR: begin
        if (nadv_s) begin
          if (!nwe_s)      fsm_d = S_WRITE;
          else if (!noe_s) fsm_d = S_READ;
          else             fsm_d = S_LATCHED;
        end
      end
      S_LATCHED: begin
        if (!nadv_s)     fsm_d = S_ADDR;
        else if (!nwe_s) fsm_d = S_WRITE;
        else if (!noe_s) fsm_d = S_READ;
      end
      S_WRITE: begin
        if (!nadv_s)    fsm_d = S_ADDR;
        else if (nwe_s) fsm_d = S_IDLE;
      end
      S_READ: begin
        if (!nadv_s)    fsm_d = S_ADDR;
        else if (noe_s) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State register plus address, data and bus-drive datapath
  always_ff @(posedge clk) begin
    if (reset_n) begin
      fsm_q     <= S_IDLE;
      addr_hi_q <= '0;
      cs_q      <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rdata_q   <= '0;
      drive_q   <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      if (fsm_q == S_ADDR && !nadv_s) addr_hi_q <= ad_hi_dly;
      if (fsm_q == S_ADDR && nadv_s)  cs_q      <= 4'b0001 << addr_hi_q;
      // Sampling stops on the edge that sees NWE_s high, so the word kept is
      // from a clock before the detected rise, while the MCU still holds it.
      if (fsm_d == S_WRITE) wdata_q <= AD[DATA_W-1:0];
      if (fsm_q == S_WRITE && nadv_s && nwe_s) rd_data_q <= wdata_q;
      if (fsm_d == S_READ && fsm_q != S_READ) rdata_q <= wr_data;
      drive_q <= (fsm_d == S_READ);
    end
  end

  assign AD      = drive_q ? {{(ADDR_W-DATA_W){1'b0}}, rdata_q} : {ADDR_W{1'bz}};
  assign rd_data = rd_data_q;
  assign cs      = cs_q;
  assign state   = (fsm_q == S_WRITE) || (fsm_q == S_READ);

endmodule
`default_nettype wire

// File: tb/tb_fsmc_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsmc_interface
// Brief    : Self-checking bench for fsmc_interface with a transaction-level
//            bus model and a per-cycle output compare process.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsmc_interface;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        NADV;
  logic        NWE;
  logic        NOE;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [3:0]  cs;
  logic        state;
  wire  [17:0] AD;

  logic        tb_en;
  logic [17:0] tb_val;

  assign AD = tb_en ? tb_val : {18{1'bz}};
  // A released bus reads all ones; a DUT drive always has AD[17:16]=0.
  pullup pu_ad (AD);

  always #5 clk = ~clk;

  fsmc_interface #(
    .ADDR_W      (18),
    .DATA_W      (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .NADV    (NADV),
    .NWE     (NWE),
    .NOE     (NOE),
    .AD      (AD),
    .rd_data (rd_data),
    .wr_data (wr_data),
    .cs      (cs),
    .state   (state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int evt_cyc  = 0;
  logic chk_en = 1'b0;

  // Bus-level model: what a correct bridge shows once strobes have settled
  logic [15:0] exp_rd   = '0;
  logic [3:0]  exp_cs   = '0;
  logic        exp_state = 1'b0;
  logic        exp_read  = 1'b0;
  logic [15:0] exp_word  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Per-cycle compare against the model, skipping the synchroniser latency
  always @(negedge clk) begin
    if (chk_en && (cyc - evt_cyc) >= 4) begin
      chk("rd_data", {2'b0, rd_data}, {2'b0, exp_rd});
      chk("cs", {14'b0, cs}, {14'b0, exp_cs});
      chk("state", {17'b0, state}, {17'b0, exp_state});
      if (tb_en)         chk("ad_no_contention", AD, tb_val);
      else if (exp_read) chk("ad_read", AD, {2'b0, exp_word});
      else               chk("ad_hiz", AD, 18'h3FFFF);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic evt();
    evt_cyc = cyc;
  endtask

  task automatic addr_phase(input logic [17:0] a);
    tick(1);
    tb_en  = 1'b1;
    tb_val = a;
    NADV   = 1'b0;
    evt();
    tick(5);
  endtask

  // kind: 0 normal write, 1 aborted by a new address, 2 NWE and NOE together
  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input int kind,
                          input logic [17:0] na);
    logic [15:0] prev;
    prev = exp_rd;
    if (kind == 2) wr_data = ~d;
    addr_phase(a);
    NADV      = 1'b1;
    NWE       = 1'b0;
    if (kind == 2) NOE = 1'b0;
    tb_val    = {2'b0, d};
    exp_cs    = 4'b0001 << a[17:16];
    exp_state = 1'b1;
    evt();
    tick(10);
    if (kind == 1) begin
      NADV      = 1'b0;
      tb_val    = na;
      exp_state = 1'b0;
      evt();
      tick(5);
      NWE = 1'b1;
      evt();
      tick(2);
      NADV   = 1'b1;
      exp_cs = 4'b0001 << na[17:16];
      evt();
      tick(1);
      tb_en = 1'b0;
      tick(5);
      chk("abort_rd_hold", {2'b0, rd_data}, {2'b0, prev});
    end else begin
      NWE = 1'b1;
      if (kind == 2) NOE = 1'b1;
      exp_state = 1'b0;
      exp_rd    = d;
      evt();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("wr_latency", {2'b0, rd_data}, {2'b0, d});
      tick(1);
      tb_en = 1'b0;
      tick(3);
    end
  endtask

  task automatic do_read(input logic [17:0] a, input logic [15:0] w, output logic [17:0] seen);
    wr_data = w;
    addr_phase(a);
    NADV      = 1'b1;
    NOE       = 1'b0;
    tb_en     = 1'b0;
    exp_cs    = 4'b0001 << a[17:16];
    exp_state = 1'b1;
    exp_read  = 1'b1;
    exp_word  = w;
    evt();
    repeat (3) @(posedge clk);
    @(negedge clk);
    seen = AD;
    chk("read_ad_early", AD, {2'b0, w});
    wr_data = 16'($urandom);
    tick(5);
    NOE       = 1'b1;
    exp_state = 1'b0;
    exp_read  = 1'b0;
    evt();
    @(posedge clk);
    @(negedge clk);
    chk("read_ad_hold", AD, {2'b0, w});
    tick(4);
  endtask

  initial begin
    logic [17:0] seen;
    logic [17:0] a;
    logic [17:0] na;
    logic [15:0] d;
    int          kind;

    reset_n = 1'b1;
    NADV    = 1'b1;
    NWE     = 1'b1;
    NOE     = 1'b1;
    tb_en   = 1'b0;
    tb_val  = '0;
    wr_data = '0;
    tick(3);
    @(negedge clk);
    chk("reset_rd_data", {2'b0, rd_data}, 18'h0);
    chk("reset_cs", {14'b0, cs}, 18'h0);
    chk("reset_state", {17'b0, state}, 18'h0);
    chk("reset_ad", AD, 18'h3FFFF);
    tick(1);
    reset_n = 1'b0;
    evt();
    chk_en = 1'b1;

    // Directed write then read of the same address
    do_write(18'h00101, 16'h0F0F, 0, 18'h0);
    chk("dir_wr_cs", {14'b0, cs}, 18'h00001);
    chk("dir_wr_data", {2'b0, rd_data}, 18'h00F0F);
    do_read(18'h00101, 16'h2321, seen);
    chk("dir_rd_ad", seen, 18'h02321);

    // Chip-select decode sweep
    do_write(18'h00000, 16'h1111, 0, 18'h0);
    chk("sweep_cs0", {14'b0, cs}, 18'h00001);
    do_write(18'h10000, 16'h2222, 0, 18'h0);
    chk("sweep_cs1", {14'b0, cs}, 18'h00002);
    do_write(18'h20000, 16'h3333, 0, 18'h0);
    chk("sweep_cs2", {14'b0, cs}, 18'h00004);
    do_write(18'h30000, 16'h4444, 0, 18'h0);
    chk("sweep_cs3", {14'b0, cs}, 18'h00008);

    // Abort and write-over-read priority
    do_write(18'h10005, 16'hBEEF, 1, 18'h20007);
    chk("abort_rd", {2'b0, rd_data}, 18'h04444);
    chk("abort_cs", {14'b0, cs}, 18'h00004);
    do_write(18'h30009, 16'h5A5A, 2, 18'h0);
    chk("both_rd", {2'b0, rd_data}, 18'h05A5A);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      a    = 18'($urandom);
      na   = 18'($urandom);
      d    = 16'($urandom);
      kind = $urandom_range(0, 3);
      if (kind == 3) do_read(a, d, seen);
      else           do_write(a, d, kind, na);
    end

    // Reset in the middle of a read while AD is driven
    wr_data = 16'hC3C3;
    addr_phase(18'h2ABCD);
    NADV      = 1'b1;
    NOE       = 1'b0;
    tb_en     = 1'b0;
    exp_cs    = 4'b0100;
    exp_state = 1'b1;
    exp_read  = 1'b1;
    exp_word  = 16'hC3C3;
    evt();
    tick(6);
    chk("pre_reset_ad", AD, 18'h0C3C3);
    chk_en  = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ad", AD, 18'h3FFFF);
    chk("midrst_state", {17'b0, state}, 18'h0);
    chk("midrst_rd_data", {2'b0, rd_data}, 18'h0);
    chk("midrst_cs", {14'b0, cs}, 18'h0);
    tick(1);
    reset_n   = 1'b0;
    NOE       = 1'b1;
    exp_rd    = '0;
    exp_cs    = '0;
    exp_state = 1'b0;
    exp_read  = 1'b0;
    evt();
    chk_en = 1'b1;
    tick(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
